// File: rtl/axis_pkg.sv
// Shared types and constants for the AXI-stream packet receiver.
package axis_pkg;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_BODY,
    RX_DISCARD
  } rx_state_t;

  localparam int PKT_CNT_W = 16;

endpackage

// File: rtl/axis_sync_fifo.sv
// Small synchronous FIFO with first-word-fall-through head; reads as zero when empty.
module axis_sync_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full,
  output logic                   empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign empty   = (level == '0);
  assign full    = (level == LVL_W'(DEPTH));
  assign head    = empty ? '0 : mem[rd_ptr];

  // Storage array holds payload only, so it carries no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      level <= level + LVL_W'(do_push) - LVL_W'(do_pop);
    end
  end

endmodule

// File: rtl/axis_packet_rx.sv
// AXI-stream slave: buffers beats, tracks packet boundaries, truncates long packets.
module axis_packet_rx
  import axis_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int DEPTH   = 4,
  parameter int MAX_LEN = 4
) (
  input  logic                           s_axis_aclk,
  input  logic                           s_axis_arstn,
  input  logic [DATA_W-1:0]              s_axis_tdata,
  input  logic                           s_axis_tvalid,
  input  logic                           s_axis_tlast,
  output logic                           s_axis_tready,
  output logic [DATA_W-1:0]              out_data,
  output logic                           out_last,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [PKT_CNT_W-1:0]           pkt_count,
  output logic [$clog2(MAX_LEN+1)-1:0]   last_len,
  output logic                           len_err
);

  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  rx_state_t        state;
  rx_state_t        next_state;
  logic [LEN_W-1:0] beat_cnt;
  logic             accept;
  logic             pop;
  logic             push;
  logic             push_last;
  logic             commit;
  logic [LEN_W-1:0] commit_len;
  logic             trunc;
  logic [LVL_W-1:0] level;
  logic [LVL_W-1:0] next_level;
  logic             full;
  logic             empty;
  logic [DATA_W:0]  head;

  assign accept     = s_axis_tvalid & s_axis_tready;
  assign out_valid  = ~empty;
  assign pop        = out_valid & out_ready;
  assign out_data   = head[DATA_W-1:0];
  assign out_last   = head[DATA_W];
  assign next_level = level + LVL_W'(push & ~full) - LVL_W'(pop);

  axis_sync_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (s_axis_aclk),
    .rst_n     (s_axis_arstn),
    .push      (push),
    .push_data ({push_last, s_axis_tdata}),
    .pop       (pop),
    .head      (head),
    .level     (level),
    .full      (full),
    .empty     (empty)
  );

  // Packet framing decisions for the beat being accepted this cycle.
  always_comb begin
    next_state = state;
    push       = 1'b0;
    push_last  = s_axis_tlast;
    commit     = 1'b0;
    commit_len = '0;
    trunc      = 1'b0;
    if (accept) begin
      case (state)
        RX_IDLE: begin
          push = 1'b1;
          if (s_axis_tlast) begin
            commit     = 1'b1;
            commit_len = LEN_W'(1);
          end else begin
            next_state = RX_BODY;
          end
        end
        RX_BODY: begin
          push = 1'b1;
          if (s_axis_tlast) begin
            commit     = 1'b1;
            commit_len = beat_cnt + LEN_W'(1);
            next_state = RX_IDLE;
          end else if (beat_cnt == LEN_W'(MAX_LEN - 1)) begin
            // Close the packet at MAX_LEN and swallow the rest of it.
            push_last  = 1'b1;
            commit     = 1'b1;
            commit_len = LEN_W'(MAX_LEN);
            trunc      = 1'b1;
            next_state = RX_DISCARD;
          end
        end
        RX_DISCARD: begin
          if (s_axis_tlast) next_state = RX_IDLE;
        end
        default: next_state = RX_IDLE;
      endcase
    end
  end

  // FSM, beat counter, statistics and the registered ready.
  always_ff @(posedge s_axis_aclk or negedge s_axis_arstn) begin
    if (!s_axis_arstn) begin
      state         <= RX_IDLE;
      beat_cnt      <= '0;
      s_axis_tready <= 1'b0;
      pkt_count     <= '0;
      last_len      <= '0;
      len_err       <= 1'b0;
    end else begin
      state   <= next_state;
      len_err <= trunc;
      if (accept) begin
        if (next_state == RX_BODY)
          beat_cnt <= (state == RX_IDLE) ? LEN_W'(1) : beat_cnt + LEN_W'(1);
        else
          beat_cnt <= '0;
      end
      if (commit) begin
        pkt_count <= pkt_count + PKT_CNT_W'(1);
        last_len  <= commit_len;
      end
      // Discarded beats are never stored, so ready stays up regardless of level.
      s_axis_tready <= (next_level < LVL_W'(DEPTH)) | (next_state == RX_DISCARD);
    end
  end

endmodule

// File: tb/tb_axis_packet_rx.sv
// Self-checking bench for axis_packet_rx against a queue-based packet model.
module tb_axis_packet_rx;

  localparam int DATA_W  = 8;
  localparam int DEPTH   = 4;
  localparam int MAX_LEN = 4;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);

  logic              clk = 1'b0;
  logic              s_axis_arstn = 1'b0;
  logic [DATA_W-1:0] s_axis_tdata = '0;
  logic              s_axis_tvalid = 1'b0;
  logic              s_axis_tlast = 1'b0;
  logic              s_axis_tready;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [15:0]       pkt_count;
  logic [LEN_W-1:0]  last_len;
  logic              len_err;

  axis_packet_rx #(.DATA_W(DATA_W), .DEPTH(DEPTH), .MAX_LEN(MAX_LEN)) dut (
    .s_axis_aclk   (clk),
    .s_axis_arstn  (s_axis_arstn),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .out_data      (out_data),
    .out_last      (out_last),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .pkt_count     (pkt_count),
    .last_len      (last_len),
    .len_err       (len_err)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  // Reference model state: what the consumer should see, and packet bookkeeping.
  logic [DATA_W:0] mq[$];
  logic [DATA_W:0] txq[$];
  int              nbeats = 0;
  bit              discarding = 0;
  logic [15:0]     exp_cnt = '0;
  int              exp_len = 0;
  bit              exp_len_err = 0;
  bit              exp_tready = 0;
  int              err_seen = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
    chk("out_data", 32'(out_data), (mq.size() > 0) ? 32'(mq[0][DATA_W-1:0]) : 32'd0);
    chk("out_last", 32'(out_last), (mq.size() > 0) ? 32'(mq[0][DATA_W]) : 32'd0);
    chk("tready", 32'(s_axis_tready), 32'(exp_tready));
    chk("pkt_count", 32'(pkt_count), 32'(exp_cnt));
    chk("last_len", 32'(last_len), 32'(exp_len));
    chk("len_err", 32'(len_err), 32'(exp_len_err));
    if (len_err === 1'b1) err_seen++;
  endtask

  task automatic commit_pkt(input int len);
    exp_cnt = exp_cnt + 16'd1;
    exp_len = len;
  endtask

  // One clock: drive inputs, check, then advance the model by the rules.
  task automatic step(input logic tv, input logic [DATA_W-1:0] td, input logic tl,
                      input logic ordy, input bit chk_on, output bit acc);
    bit trunc_now;
    s_axis_tvalid = tv;
    s_axis_tdata  = td;
    s_axis_tlast  = tl;
    out_ready     = ordy;
    #1;
    if (chk_on) check_outputs();
    acc = tv & exp_tready;
    trunc_now = 0;
    if ((mq.size() > 0) && ordy) void'(mq.pop_front());
    if (acc) begin
      if (discarding) begin
        if (tl) discarding = 0;
      end else begin
        nbeats++;
        if (tl) begin
          mq.push_back({1'b1, td});
          commit_pkt(nbeats);
          nbeats = 0;
        end else if (nbeats == MAX_LEN) begin
          mq.push_back({1'b1, td});
          commit_pkt(MAX_LEN);
          trunc_now = 1;
          discarding = 1;
          nbeats = 0;
        end else begin
          mq.push_back({1'b0, td});
        end
      end
    end
    exp_len_err = trunc_now;
    exp_tready  = (mq.size() < DEPTH) || discarding;
    @(negedge clk);
  endtask

  // Offer queued beats for n cycles; mode 0/1 fixed out_ready, 2 random traffic.
  task automatic pump(input int n, input int mode);
    bit acc;
    logic tv, ordy;
    for (int i = 0; i < n; i++) begin
      ordy = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'(mode);
      tv   = (txq.size() > 0) && ((mode != 2) || ($urandom_range(0, 3) != 0));
      if (txq.size() > 0)
        step(tv, txq[0][DATA_W-1:0], txq[0][DATA_W], ordy, 1'b1, acc);
      else
        step(1'b0, DATA_W'($urandom), 1'($urandom), ordy, 1'b1, acc);
      if (acc) void'(txq.pop_front());
    end
  endtask

  task automatic queue_pkt(input int len, input logic [DATA_W-1:0] first, input int stride);
    for (int i = 0; i < len; i++)
      txq.push_back({1'(i == len - 1), DATA_W'(first + DATA_W'(i * stride))});
  endtask

  task automatic do_reset();
    s_axis_arstn = 1'b0;
    #1;
    mq.delete();
    txq.delete();
    nbeats = 0;
    discarding = 0;
    exp_cnt = '0;
    exp_len = 0;
    exp_len_err = 0;
    exp_tready = 0;
    check_outputs();
    @(negedge clk);
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    s_axis_arstn = 1'b1;
  endtask

  initial begin
    bit acc;
    @(negedge clk);
    do_reset();

    // 4-beat packet, consumer always ready
    queue_pkt(4, 8'h00, 5);
    pump(12, 1);
    chk("t2_pkt_count", 32'(pkt_count), 32'd1);
    chk("t2_last_len", 32'(last_len), 32'd4);
    chk("t2_len_err_pulses", 32'(err_seen), 32'd0);

    // Single beat with tlast
    queue_pkt(1, 8'hA5, 0);
    step(1'b1, 8'hA5, 1'b1, 1'b0, 1'b1, acc);
    void'(txq.pop_front());
    chk("t5_out_data", 32'(out_data), 32'hA5);
    chk("t5_out_last", 32'(out_last), 32'd1);
    chk("t5_last_len", 32'(last_len), 32'd1);
    pump(3, 1);

    // Over-length packet 1..6 gets truncated
    queue_pkt(6, 8'h01, 1);
    pump(12, 1);
    chk("t4_len_err_pulses", 32'(err_seen), 32'd1);
    chk("t4_pkt_count", 32'(pkt_count), 32'd3);
    queue_pkt(1, 8'h3C, 0);
    pump(4, 1);
    chk("t4_next_len", 32'(last_len), 32'd1);

    // Backpressure: 6 beats (two 3-beat packets) against a stalled consumer
    queue_pkt(3, 8'h10, 1);
    queue_pkt(3, 8'h20, 1);
    pump(8, 0);
    chk("t3_left_unsent", 32'(txq.size()), 32'd2);
    chk("t3_tready_full", 32'(s_axis_tready), 32'd0);
    pump(12, 1);
    chk("t3_all_drained", 32'(out_valid), 32'd0);

    // Reset mid-packet with two beats buffered
    queue_pkt(3, 8'h40, 1);
    pump(2, 0);
    chk("t1_level_before", 32'(out_valid), 32'd1);
    do_reset();
    queue_pkt(2, 8'h50, 1);
    pump(8, 1);
    chk("t1_after_count", 32'(pkt_count), 32'd1);
    chk("t1_after_len", 32'(last_len), 32'd2);

    // Steady streaming, then packet counter wrap
    do_reset();
    for (int i = 0; i < 12; i++) begin
      step(1'b1, DATA_W'(i), 1'b1, 1'b1, 1'b1, acc);
      if (i > 1) chk("t6_tready", 32'(s_axis_tready), 32'd1);
    end
    while (exp_cnt != 16'hFFFF) step(1'b1, DATA_W'($urandom), 1'b1, 1'b1, 1'b0, acc);
    step(1'b1, 8'h77, 1'b1, 1'b1, 1'b1, acc);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, acc);
    chk("t6_wrap", 32'(pkt_count), 32'd0);
    pump(3, 1);

    // Randomized packets and traffic
    for (int p = 0; p < 60; p++)
      queue_pkt($urandom_range(1, 6), DATA_W'($urandom), 1);
    pump(500, 2);
    pump(60, 1);
    chk("rand_all_sent", 32'(txq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
